// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit_serializer block.
package bit_serializer_pkg;

  // Default parallel word width.
  localparam int DEFAULT_WIDTH = 8;

  // Serializer control states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/ser_bit_counter.sv
// Down-counter tracking the remaining bits of the word being serialized.
// Loads with load_val, decrements on dec and saturates at zero.
module ser_bit_counter
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Count register: load wins over decrement; never wraps below zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter, MSB first, with a load/ready handshake and
// a shift_en strobe that stretches the current bit while low.
// Optional one-word holding buffer for gapless back-to-back words is
// enabled by defining BIT_SERIALIZER_HOLD_BUF_EN.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  input  logic             shift_en,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic             done_q, done_next;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             accept;

`ifdef BIT_SERIALIZER_HOLD_BUF_EN
  logic [WIDTH-1:0] hold_buf;
  logic             buf_full, buf_set, buf_clr, last;

  assign ready = !buf_full;
  assign last  = (state == SHIFT) && shift_en && cnt_zero;
`else
  assign ready = (state == IDLE);
`endif

  assign accept = load && ready;

  ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (LAST_IDX),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state, shift-register and handshake decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    next_state = state;
    shreg_next = shreg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    done_next  = 1'b0;
`ifdef BIT_SERIALIZER_HOLD_BUF_EN
    buf_set    = 1'b0;
    buf_clr    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = SHIFT;
          shreg_next = data_in;
          cnt_load   = 1'b1;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (!cnt_zero) begin
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
            cnt_dec    = 1'b1;
          end else begin
`ifdef BIT_SERIALIZER_HOLD_BUF_EN
            if (buf_full) begin
              shreg_next = hold_buf;
              cnt_load   = 1'b1;
              buf_clr    = 1'b1;
            end else if (accept) begin
              shreg_next = data_in;
              cnt_load   = 1'b1;
            end else begin
              next_state = IDLE;
              done_next  = 1'b1;
            end
`else
            next_state = IDLE;
            done_next  = 1'b1;
`endif
          end
        end
`ifdef BIT_SERIALIZER_HOLD_BUF_EN
        // A load that does not coincide with last-bit consumption parks
        // in the buffer until the current word drains.
        if (accept && !last) begin
          buf_set = 1'b1;
        end
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  // State, shift register and done pulse registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      shreg  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      shreg  <= shreg_next;
      done_q <= done_next;
    end
  end

`ifdef BIT_SERIALIZER_HOLD_BUF_EN
  // Holding buffer; reset discards any parked word.
  always_ff @(posedge clk) begin
    // NOTE: the buffer data is reset too, so a discarded word can never
    // reappear on w after reset.
    if (!resetn) begin
      hold_buf <= '0;
      buf_full <= 1'b0;
    end else if (buf_set) begin
      hold_buf <= data_in;
      buf_full <= 1'b1;
    end else if (buf_clr) begin
      buf_full <= 1'b0;
    end
  end
`endif

  // Outputs decode from registers only.
  assign w_valid = (state == SHIFT);
  assign busy    = (state == SHIFT);
  assign w       = w_valid && shreg[WIDTH-1];
  assign done    = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: stimulus pushes expected serial
// events ({done, w_valid, w}) into a queue; a negedge monitor pops and
// compares whenever the DUT shows a valid bit or a done pulse.
// Define BIT_SERIALIZER_HOLD_BUF_EN to exercise the holding buffer.
module tb_bit_serializer;

  localparam int WIDTH = 8;
  localparam logic [2:0] EV_DONE = 3'b100;

  logic             clk = 1'b0;
  logic             resetn;
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             shift_en;
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;

  int         n_vec  = 0;
  int         n_fail = 0;
  logic       mon_en = 1'b0;
  logic [2:0] sb_q[$];

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .data_in  (data_in),
    .load     (load),
    .ready    (ready),
    .shift_en (shift_en),
    .w        (w),
    .w_valid  (w_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bit(input logic b);
    sb_q.push_back({1'b0, 1'b1, b});
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) push_bit(d[i]);
  endtask

  task automatic push_done();
    sb_q.push_back(EV_DONE);
  endtask

  // Monitor: pop and compare on every valid bit or done pulse.
  initial begin
    logic [2:0] exp_code;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (w_valid === 1'b1 || done === 1'b1) begin
          if (sb_q.size() == 0) begin
            check("unexpected_output", {29'd0, done, w_valid, w}, 32'd0);
          end else begin
            exp_code = sb_q.pop_front();
            check("serial_event", {29'd0, done, w_valid, w}, {29'd0, exp_code});
          end
        end else begin
          check("w_zero_when_invalid", {31'd0, w}, 32'd0);
        end
      end
    end
  end

  initial begin
    logic [10:0] stall_seq;
    resetn   = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    data_in  = '0;
    tick();
    tick();
    check("rst_ready", ready, 1);
    check("rst_w", w, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    resetn = 1'b1;
    mon_en = 1'b1;
    tick();

    // Plain word 8'hB6, shift_en held high.
    push_word(8'hB6);
    push_done();
    data_in = 8'hB6; load = 1'b1; shift_en = 1'b1;
    tick();
    load = 1'b0;
    check("s1_busy_c1", busy, 1);
    check("s1_valid_c1", w_valid, 1);
`ifdef BIT_SERIALIZER_HOLD_BUF_EN
    check("s1_ready_c1", ready, 1);
`else
    check("s1_ready_c1", ready, 0);
`endif
    repeat (8) tick();
    check("s1_done_c9", done, 1);
    check("s1_ready_c9", ready, 1);
    check("s1_busy_c9", busy, 0);
    tick();
    check("s1_done_c10", done, 0);
    tick();

    // Stall: shift_en low for cycles 3..5 holds the third bit four cycles.
    stall_seq = 11'b10111110110;
    for (int i = 10; i >= 0; i--) push_bit(stall_seq[i]);
    push_done();
    data_in = 8'hB6; load = 1'b1; shift_en = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      shift_en = !(c >= 3 && c <= 5);
      tick();
    end
    shift_en = 1'b1;
    check("s2_done_c12", done, 1);
    check("s2_valid_c12", w_valid, 0);
    tick();
    tick();

`ifdef BIT_SERIALIZER_HOLD_BUF_EN
    // Second word parked in the buffer during SHIFT: 16 gapless bits.
    push_word(8'hB6);
    push_word(8'h0F);
    push_done();
    data_in = 8'hB6; load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check("s4_gapless", w_valid, 1);
      if (c == 3) check("s4_ready_full", ready, 0);
      load    = (c == 2);
      data_in = (c == 2) ? 8'h0F : 8'h00;
      tick();
    end
    load = 1'b0;
    check("s4_done_c17", done, 1);
    tick();
    tick();

    // Load on the same edge as last-bit consumption with an empty buffer.
    push_word(8'hC3);
    push_word(8'h5A);
    push_done();
    data_in = 8'hC3; load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check("s4b_gapless", w_valid, 1);
      load    = (c == 8);
      data_in = (c == 8) ? 8'h5A : 8'h00;
      tick();
    end
    load = 1'b0;
    check("s4b_done_c17", done, 1);
    tick();
    tick();
`else
    // Loads during SHIFT are ignored: only 8'hB6 comes out.
    push_word(8'hB6);
    push_done();
    data_in = 8'hB6; load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      load    = (c == 3 || c == 4);
      data_in = load ? 8'h0F : 8'hB6;
      if (c == 3) check("s3_ready_shift", ready, 0);
      tick();
    end
    load = 1'b0;
    check("s3_done_c9", done, 1);
    repeat (4) tick();
    check("s3_idle_after", w_valid, 0);
`endif

    // Reset at bit 4 of 8'hFF: abort, no done.
    repeat (4) push_bit(1'b1);
    data_in = 8'hFF; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("s5_w", w, 0);
    check("s5_w_valid", w_valid, 0);
    check("s5_ready", ready, 1);
    check("s5_busy", busy, 0);
    check("s5_done", done, 0);
    tick();
    check("s5_done_next", done, 0);
    repeat (2) tick();

    // load and resetn=0 on the same edge: reset wins.
    resetn = 1'b0; load = 1'b1; data_in = 8'hAA;
    tick();
    resetn = 1'b1; load = 1'b0;
    check("s6_w_valid", w_valid, 0);
    check("s6_busy", busy, 0);
    check("s6_ready", ready, 1);
    check("s6_shreg", dut.shreg, 0);
    tick();
    check("s6_w_valid_next", w_valid, 0);
    repeat (3) tick();

    check("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
